// File: rtl/modified_booth_multiplier_sync.sv
// Signed 8x8 radix-4 modified Booth multiplier: Wallace carry-save reduction,
// hybrid carry-lookahead / carry-select final adder, one registered output stage.
module modified_booth_multiplier_sync (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic [15:0] product
);

    localparam logic CARRY_IN = 1'b0;

    logic [8:0]  b_ext;
    logic [9:0]  a_ext;
    logic [2:0]  triplet  [4];
    logic [3:0]  digit_one;
    logic [3:0]  digit_two;
    logic [3:0]  digit_neg;
    logic [9:0]  pp_mag   [4];
    logic [9:0]  pp_raw   [4];
    logic [15:0] pp_row   [4];
    logic [6:0]  corr_row;

    logic [1:0]  fa_bits;
    logic [15:0] l1_sum;
    logic [15:0] l1_carry;
    logic [15:0] l2_sum;
    logic [15:0] l2_carry;
    logic [15:0] row_sum;
    logic [15:0] row_carry;

    logic [5:0]  lo0;
    logic [5:0]  lo1;
    logic        carry4;
    logic        carry8;
    logic [7:0]  hi_c0;
    logic [7:0]  hi_c1;
    logic [15:0] final_sum;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
        full_add = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        half_add = {x & y, x ^ y};
    endfunction

    // Returns {group generate, group propagate, sum[3:0]} for a 4-bit lookahead block.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cla4 = {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p, p ^ c};
    endfunction

    function automatic logic [7:0] ripple8(input logic [7:0] x, input logic [7:0] y, input logic cin);
        logic       c;
        logic [7:0] s;
        c = cin;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            s[k] = x[k] ^ y[k] ^ c;
            c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
        end
        ripple8 = s;
    endfunction

    // Radix-4 recoding: negative digits are ones-complemented here and the +1
    // lands in corr_row at the digit's weight, so it rides through the tree.
    always_comb begin
        b_ext    = {multiplier, 1'b0};
        a_ext    = {{2{multiplicand[7]}}, multiplicand};
        corr_row = '0;
        for (int i = 0; i < 4; i++) begin
            triplet[i]     = b_ext[2*i +: 3];
            digit_one[i]   = triplet[i][1] ^ triplet[i][0];
            digit_two[i]   = (triplet[i] == 3'b011) || (triplet[i] == 3'b100);
            digit_neg[i]   = triplet[i][2];
            pp_mag[i]      = digit_one[i] ? a_ext :
                             (digit_two[i] ? {a_ext[8:0], 1'b0} : 10'd0);
            pp_raw[i]      = digit_neg[i] ? ~pp_mag[i] : pp_mag[i];
            pp_row[i]      = {{6{pp_raw[i][9]}}, pp_raw[i]} << (2*i);
            corr_row[2*i]  = digit_neg[i];
        end
    end

    // Five rows (four partial products plus correction bits) compressed to two.
    always_comb begin
        fa_bits   = '0;
        l1_sum    = '0;
        l1_carry  = '0;
        l2_sum    = '0;
        l2_carry  = '0;
        row_sum   = '0;
        row_carry = '0;
        for (int j = 0; j < 16; j++) begin
            fa_bits   = full_add(pp_row[0][j], pp_row[1][j], pp_row[2][j]);
            l1_sum[j] = fa_bits[0];
            if (j < 15) begin
                l1_carry[j+1] = fa_bits[1];
            end
        end
        for (int j = 0; j < 16; j++) begin
            fa_bits   = full_add(l1_sum[j], l1_carry[j], pp_row[3][j]);
            l2_sum[j] = fa_bits[0];
            if (j < 15) begin
                l2_carry[j+1] = fa_bits[1];
            end
        end
        for (int j = 0; j < 16; j++) begin
            if (j < 7) begin
                fa_bits = full_add(l2_sum[j], l2_carry[j], corr_row[j]);
            end else begin
                fa_bits = half_add(l2_sum[j], l2_carry[j]);
            end
            row_sum[j] = fa_bits[0];
            if (j < 15) begin
                row_carry[j+1] = fa_bits[1];
            end
        end
    end

    // Upper byte is precomputed for both carry-ins and picked by the lookahead carry out of bit 7.
    always_comb begin
        lo0       = cla4(row_sum[3:0], row_carry[3:0], CARRY_IN);
        carry4    = lo0[5] | (lo0[4] & CARRY_IN);
        lo1       = cla4(row_sum[7:4], row_carry[7:4], carry4);
        carry8    = lo1[5] | (lo1[4] & carry4);
        hi_c0     = ripple8(row_sum[15:8], row_carry[15:8], 1'b0);
        hi_c1     = ripple8(row_sum[15:8], row_carry[15:8], 1'b1);
        final_sum = {carry8 ? hi_c1 : hi_c0, lo1[3:0], lo0[3:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else begin
            product <= final_sum;
        end
    end

endmodule

// File: tb/tb_modified_booth_multiplier_sync.sv
// Self-checking bench for modified_booth_multiplier_sync against a plain
// signed-arithmetic reference model.
module tb_modified_booth_multiplier_sync;

    logic        clk;
    logic        rst_n;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    modified_booth_multiplier_sync dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 16'(sa * sb);
    endfunction

    task automatic test_reset();
        rst_n        = 1'b0;
        multiplicand = 8'h5A;
        multiplier   = 8'h33;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (product !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_hold[%0d]: got %h expected 0000", k, product);
            end
        end
        rst_n        = 1'b1;
        multiplicand = 8'h0C;
        multiplier   = 8'hFD;
        @(negedge clk);
        checks++;
        if (product !== 16'hFFDC) begin
            errors++;
            $display("[TB] FAIL first_after_reset: got %h expected ffdc", product);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [8];
        logic [7:0]  tb [8];
        logic [15:0] te [8];
        ta = '{8'h1B, 8'h0A, 8'hF6, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h00};
        tb = '{8'hF1, 8'h0A, 8'h0A, 8'h80, 8'h0A, 8'h80, 8'h00, 8'h00};
        te = '{16'hFE6B, 16'h0064, 16'hFF9C, 16'h4000, 16'hFB00, 16'h0000, 16'h0000, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            multiplicand = ta[k];
            multiplier   = tb[k];
            @(negedge clk);
            checks++;
            if (product !== te[k]) begin
                errors++;
                $display("[TB] FAIL directed[%0d] %h*%h: got %h expected %h",
                         k, ta[k], tb[k], product, te[k]);
            end
        end
    endtask

    task automatic test_back_to_back(input int count);
        logic [15:0] exp_q [$];
        logic [15:0] expv;
        @(negedge clk);
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        exp_q.push_back(ref_product(multiplicand, multiplier));
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            expv = exp_q.pop_front();
            checks++;
            if (product !== expv) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", k, product, expv);
            end
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            exp_q.push_back(ref_product(multiplicand, multiplier));
        end
        @(negedge clk);
        expv = exp_q.pop_front();
        checks++;
        if (product !== expv) begin
            errors++;
            $display("[TB] FAIL back_to_back_last: got %h expected %h", product, expv);
        end
    endtask

    // Every corner value on one operand against all 256 values of the other, one per cycle.
    task automatic test_sweep();
        logic [7:0]  corner [12];
        logic [15:0] exp_q [$];
        logic [15:0] expv;
        int          pending;
        corner  = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81,
                    8'hFF, 8'hFE, 8'h55, 8'hAA, 8'h40, 8'hC0};
        pending = 0;
        for (int side = 0; side < 2; side++) begin
            for (int c = 0; c < 12; c++) begin
                for (int v = 0; v < 256; v++) begin
                    @(negedge clk);
                    if (pending != 0) begin
                        expv = exp_q.pop_front();
                        checks++;
                        if (product !== expv) begin
                            errors++;
                            $display("[TB] FAIL sweep %h*%h: got %h expected %h",
                                     multiplicand, multiplier, product, expv);
                        end
                    end
                    if (side == 0) begin
                        multiplicand = corner[c];
                        multiplier   = 8'(v);
                    end else begin
                        multiplicand = 8'(v);
                        multiplier   = corner[c];
                    end
                    exp_q.push_back(ref_product(multiplicand, multiplier));
                    pending = 1;
                end
            end
        end
        @(negedge clk);
        expv = exp_q.pop_front();
        checks++;
        if (product !== expv) begin
            errors++;
            $display("[TB] FAIL sweep_last: got %h expected %h", product, expv);
        end
    endtask

    task automatic test_hold();
        logic [15:0] expv;
        @(negedge clk);
        multiplicand = 8'hE3;
        multiplier   = 8'h47;
        expv         = ref_product(8'hE3, 8'h47);
        @(posedge clk);
        #1;
        checks++;
        if (product !== expv) begin
            errors++;
            $display("[TB] FAIL hold_load: got %h expected %h", product, expv);
        end
        #1;
        multiplicand = 8'h11;
        multiplier   = 8'h9C;
        #2;
        checks++;
        if (product !== expv) begin
            errors++;
            $display("[TB] FAIL hold_between_edges: got %h expected %h", product, expv);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        multiplicand = 8'h80;
        multiplier   = 8'h80;
        @(negedge clk);
        checks++;
        if (product !== 16'h4000) begin
            errors++;
            $display("[TB] FAIL pre_reset_value: got %h expected 4000", product);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (product !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL async_clear: got %h expected 0000", product);
        end
        @(negedge clk);
        checks++;
        if (product !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_across_edge: got %h expected 0000", product);
        end
        multiplicand = 8'h1B;
        multiplier   = 8'hF1;
        rst_n        = 1'b1;
        #1;
        checks++;
        if (product !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL release_no_edge: got %h expected 0000", product);
        end
        @(negedge clk);
        checks++;
        if (product !== 16'hFE6B) begin
            errors++;
            $display("[TB] FAIL first_after_midstream_reset: got %h expected fe6b", product);
        end
    endtask

    initial begin
        $display("[TB] starting modified_booth_multiplier_sync bench");
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_back_to_back(2000);
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
